// File: rtl/lab3_pkg.sv
// Shared types and constants for the minterm reader: FSM states, code/function
// widths and the default expected minterm masks.
package lab3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CODE_W    = 3;
  localparam int NUM_CODES = 8;
  localparam int NUM_FUNCS = 3;

  localparam logic [NUM_CODES-1:0] EXP_0_DEF = 8'h39;
  localparam logic [NUM_CODES-1:0] EXP_1_DEF = 8'h5C;
  localparam logic [NUM_CODES-1:0] EXP_2_DEF = 8'h41;

endpackage

// File: rtl/minterm_reader_tick_divider.sv
// Prescaler for the minterm reader: counts while enabled and flags the
// all-ones count, which marks the last clock of one dwell.
module tick_divider #(
  parameter int DIV_WIDTH = 25
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable & (&cnt_q);

endmodule

// File: rtl/minterm_reader.sv
// Sweeps a 3-bit code through a function block and rebuilds one minterm mask
// per output. Optional macro MINTERM_READER_AUTO_REPEAT_EN re-sweeps after one dwell in DONE.
module minterm_reader
  import lab3_pkg::*;
#(
  parameter int                    DIV_WIDTH = 25,
  parameter logic [NUM_CODES-1:0]  EXP_0     = EXP_0_DEF,
  parameter logic [NUM_CODES-1:0]  EXP_1     = EXP_1_DEF,
  parameter logic [NUM_CODES-1:0]  EXP_2     = EXP_2_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_FUNCS-1:0] z_in,
  output logic [CODE_W-1:0]    x_out,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_CODES-1:0] mask_0,
  output logic [NUM_CODES-1:0] mask_1,
  output logic [NUM_CODES-1:0] mask_2,
  output logic                 match
);

  state_t                                   state_q, state_d;
  logic [CODE_W-1:0]                        x_q, x_d;
  logic [NUM_FUNCS-1:0][NUM_CODES-1:0]      work_q, work_d;
  logic [NUM_FUNCS-1:0][NUM_CODES-1:0]      mask_q, mask_d;
  logic                                     match_q, match_d;
  logic                                     presc_clr, presc_en, tick;

  tick_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_div (
    .clock  (clock),
    .reset  (reset),
    .clear  (presc_clr),
    .enable (presc_en),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    work_d    = work_q;
    mask_d    = mask_q;
    match_d   = match_q;
    presc_clr = 1'b0;
    presc_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SWEEP;
          presc_clr = 1'b1;
          x_d       = '0;
          work_d    = '0;
        end
      end
      SWEEP: begin
        presc_en = 1'b1;
        if (tick) begin
          for (int k = 0; k < NUM_FUNCS; k++) begin
            work_d[k][x_q] = z_in[k];
          end
          if (x_q == CODE_W'(NUM_CODES - 1)) begin
            // Shadowed outputs only move at the completing tick.
            mask_d  = work_d;
            match_d = (work_d[0] == EXP_0) && (work_d[1] == EXP_1) &&
                      (work_d[2] == EXP_2);
            state_d = DONE;
          end else begin
            x_d = x_q + CODE_W'(1);
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d   = SWEEP;
          presc_clr = 1'b1;
          x_d       = '0;
          work_d    = '0;
        end else begin
`ifdef MINTERM_READER_AUTO_REPEAT_EN
          presc_en = 1'b1;
          if (tick) begin
            state_d   = SWEEP;
            presc_clr = 1'b1;
            x_d       = '0;
            work_d    = '0;
          end
`else
          state_d = DONE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      work_q  <= '0;
      mask_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      work_q  <= work_d;
      mask_q  <= mask_d;
      match_q <= match_d;
    end
  end

  assign x_out  = x_q;
  assign busy   = (state_q == SWEEP);
  assign done   = (state_q == DONE);
  assign mask_0 = mask_q[0];
  assign mask_1 = mask_q[1];
  assign mask_2 = mask_q[2];
  assign match  = match_q;

endmodule

// File: tb/tb_minterm_reader.sv
// Directed bench for minterm_reader (DIV_WIDTH=2): a function-block model drives
// z_in and a scoreboard holds the masks expected from each sweep.
module tb_minterm_reader;

  localparam int         DW = 2;
  localparam logic [7:0] R0 = 8'h39;
  localparam logic [7:0] R1 = 8'h5C;
  localparam logic [7:0] R2 = 8'h41;

  typedef struct {
    logic [7:0] m0;
    logic [7:0] m1;
    logic [7:0] m2;
    logic       mt;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] z_in;
  logic [2:0] x_out;
  logic       busy, done, match;
  logic [7:0] mask_0, mask_1, mask_2;

  bit         stuck2 = 1'b0;
  bit         inv1   = 1'b0;
  bit         settle = 1'b0;
  logic [2:0] x_dly  = 3'd0;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  minterm_reader #(.DIV_WIDTH(DW)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .z_in   (z_in),
    .x_out  (x_out),
    .busy   (busy),
    .done   (done),
    .mask_0 (mask_0),
    .mask_1 (mask_1),
    .mask_2 (mask_2),
    .match  (match)
  );

  always #5 clock = ~clock;

  always @(posedge clock) x_dly <= x_out;

  function automatic logic [2:0] fmodel(logic [2:0] c, bit inv, bit stk);
    logic [2:0] z;
    z[0] = R0[c];
    z[1] = R1[c] ^ inv;
    z[2] = R2[c] & ~stk;
    return z;
  endfunction

  assign z_in = fmodel(settle ? x_dly : x_out, inv1, stuck2);

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_exp();
    exp_t       e;
    logic [2:0] z;
    for (int i = 0; i < 8; i++) begin
      z       = fmodel(3'(i), inv1, stuck2);
      e.m0[i] = z[0];
      e.m1[i] = z[1];
      e.m2[i] = z[2];
    end
    e.mt = (e.m0 == R0) && (e.m1 == R1) && (e.m2 == R2);
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    chk({tag, "_sb_size"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_mask_0"}, mask_0, e.m0);
      chk({tag, "_mask_1"}, mask_1, e.m1);
      chk({tag, "_mask_2"}, mask_2, e.m2);
      chk({tag, "_match"},  match,  e.mt);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clock);
      #1;
      cyc++;
      if (done) break;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic do_sweep(input string tag);
    int c;
    push_exp();
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk({tag, "_busy_start"}, busy, 1'b1);
    wait_done(c);
    chk({tag, "_latency"}, c, 32);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_x_end"}, x_out, 3'd7);
    pop_cmp(tag);
  endtask

  initial begin
    int c;
    reset = 1'b1;
    start = 1'b0;
    step(3);
    chk("rst_x", x_out, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_masks", {mask_0, mask_1, mask_2}, 24'h0);
    chk("rst_match", match, 1'b0);
    reset = 1'b0;
    step(1);

    do_sweep("ref");

    stuck2 = 1'b1;
    apply_reset();
    do_sweep("stuck_z2");
    stuck2 = 1'b0;

    settle = 1'b1;
    apply_reset();
    do_sweep("settle");
    settle = 1'b0;

    // Mid-sweep reset at T0+13, also colliding with start.
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(12);
    reset = 1'b1;
    start = 1'b1;
    step(1);
    chk("midrst_x", x_out, 3'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_masks", {mask_0, mask_1, mask_2}, 24'h0);
    reset = 1'b0;
    start = 1'b0;
    do_sweep("after_rst");

    // start held through a whole sweep.
    push_exp();
    start = 1'b1;
    step(1);
    chk("held_busy", busy, 1'b1);
    wait_done(c);
    chk("held_latency", c, 32);
    pop_cmp("held");
    step(1);
    chk("held_restart_busy", busy, 1'b1);
    chk("held_restart_x", x_out, 3'd0);
    start = 1'b0;
    push_exp();
    step(8);
    chk("shadow_mask_0", mask_0, R0);
    chk("shadow_done", done, 1'b0);
    wait_done(c);
    chk("held2_latency", c, 24);
    pop_cmp("held2");

`ifdef MINTERM_READER_AUTO_REPEAT_EN
    apply_reset();
    do_sweep("auto1");
    inv1 = 1'b1;
    push_exp();
    step(3);
    chk("auto_done_dwell", done, 1'b1);
    step(1);
    chk("auto_resweep_busy", busy, 1'b1);
    chk("auto_resweep_x", x_out, 3'd0);
    step(10);
    chk("auto_shadow_mask_1", mask_1, R1);
    chk("auto_shadow_match", match, 1'b1);
    wait_done(c);
    chk("auto2_latency", c, 22);
    pop_cmp("auto2");
    inv1 = 1'b0;
`else
    apply_reset();
    do_sweep("hold");
    step(40);
    chk("hold_done", done, 1'b1);
    chk("hold_x", x_out, 3'd7);
    chk("hold_busy", busy, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
